// File: rtl/spi_controller.sv
// spi_controller: SPI mode-0 write-only initiator.
// Serialises one 16-bit frame {1'b1, addr[6:0], data[7:0]} MSB first on
// ncs/sclk/copi, then holds ncs high for a minimum gap before the next frame.
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both high; req_ready is high only while idle, so a request
// presented while busy simply waits. done pulses for one cycle as ncs rises.
module spi_controller #(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_data,
  output logic       done,
  output logic       ncs,
  output logic       sclk,
  output logic       copi,
  output logic [2:0] dbg_state
);

  localparam int HW = $clog2(CLK_DIV);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_t;

  state_t        state, state_n;
  logic [HW-1:0] half_cnt, half_cnt_n;
  logic [3:0]    bit_cnt, bit_cnt_n;
  logic [GW-1:0] gap_cnt, gap_cnt_n;
  logic [15:0]   shreg, shreg_n;
  logic          phase_high, phase_high_n;
  logic          half_last;
  logic          ncs_n, sclk_n, copi_n, done_n;

  assign half_last = (half_cnt == HALF_LAST);
  assign req_ready = (state == IDLE);
  assign dbg_state = state;

  // Next-state, counter and shift-register logic.
  always_comb begin
    state_n      = state;
    half_cnt_n   = half_cnt;
    bit_cnt_n    = bit_cnt;
    gap_cnt_n    = gap_cnt;
    shreg_n      = shreg;
    phase_high_n = phase_high;
    done_n       = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          state_n    = SETUP;
          shreg_n    = {1'b1, req_addr, req_data};
          half_cnt_n = '0;
        end
      end
      SETUP: begin
        if (half_last) begin
          state_n      = SHIFT;
          half_cnt_n   = '0;
          phase_high_n = 1'b1;
          bit_cnt_n    = 4'd15;
        end else begin
          half_cnt_n = half_cnt + 1'b1;
        end
      end
      SHIFT: begin
        if (half_last) begin
          half_cnt_n = '0;
          if (phase_high) begin
            // Falling edge: present the next bit; zeros shift in behind,
            // so copi is 0 after the 16th fall.
            phase_high_n = 1'b0;
            shreg_n      = {shreg[14:0], 1'b0};
          end else if (bit_cnt == 4'd0) begin
            state_n = HOLD;
          end else begin
            bit_cnt_n    = bit_cnt - 1'b1;
            phase_high_n = 1'b1;
          end
        end else begin
          half_cnt_n = half_cnt + 1'b1;
        end
      end
      HOLD: begin
        if (half_last) begin
          state_n    = GAP;
          gap_cnt_n  = '0;
          half_cnt_n = '0;
          done_n     = 1'b1;
        end else begin
          half_cnt_n = half_cnt + 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_n = IDLE;
        end else begin
          gap_cnt_n = gap_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Pin values are decoded from the next state so they can be registered.
  always_comb begin
    ncs_n  = !((state_n == SETUP) || (state_n == SHIFT) || (state_n == HOLD));
    sclk_n = (state_n == SHIFT) && phase_high_n;
    copi_n = ((state_n == SETUP) || (state_n == SHIFT)) ? shreg_n[15] : 1'b0;
  end

  // State, counters and registered pin outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      half_cnt   <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      shreg      <= '0;
      phase_high <= 1'b0;
      ncs        <= 1'b1;
      sclk       <= 1'b0;
      copi       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      half_cnt   <= half_cnt_n;
      bit_cnt    <= bit_cnt_n;
      gap_cnt    <= gap_cnt_n;
      shreg      <= shreg_n;
      phase_high <= phase_high_n;
      ncs        <= ncs_n;
      sclk       <= sclk_n;
      copi       <= copi_n;
      done       <= done_n;
    end
  end

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: table vectors, back-to-back, busy isolation,
// mid-frame reset and random frames, all decoded from the SPI pins.
module tb_spi_controller;

  localparam int CD  = 4;
  localparam int GAP = 8;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [6:0] req_addr = '0;
  logic [7:0] req_data = '0;
  logic       done, ncs, sclk, copi;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  spi_controller #(.CLK_DIV(CD), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .done(done), .ncs(ncs),
    .sclk(sclk), .copi(copi), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q[$];
  int exp_done = 0;
  int acc_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic check_ge(input string name, input int act, input int min);
    checks++;
    if (act < min) begin
      failures++;
      $display("FAIL %s actual=%0d required>=%0d", name, act, min);
    end
  endtask

  // ---------------- pin monitor ----------------
  bit          in_frame = 0, have_prev = 0, wait_ready = 0;
  int          mon_edges = 0, fall_c = 0, first_rise = 0, frame_acc = 0;
  int          high_run = 0, last_chg = 0, frames_done = 0, done_total = 0;
  int          copi_viol = 0, pre_viol = 0, ready_viol = 0;
  logic [15:0] word = '0;
  logic        prev_sclk = 1'b0, prev_copi = 1'b0, hi_copi = 1'b0;
  logic [15:0] exp_w;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame = 0; have_prev = 0; wait_ready = 0; mon_edges = 0;
      prev_sclk = 1'b0; prev_copi = 1'b0; last_chg = cyc;
    end else begin
      if (done) done_total++;
      if (copi != prev_copi) last_chg = cyc;
      if (!ncs && req_ready) ready_viol++;
      if (!ncs) begin
        if (!in_frame) begin
          in_frame = 1; mon_edges = 0; word = '0; fall_c = cyc; first_rise = -1;
          frame_acc = acc_cyc;
          check("ncs_fall_latency", cyc - acc_cyc, 0);
          if (have_prev) check_ge("gap_high_cycles", high_run, GAP);
          have_prev = 0;
        end
        if (sclk && !prev_sclk) begin
          mon_edges++;
          word = {word[14:0], copi};
          if (mon_edges == 1) first_rise = cyc;
          hi_copi = copi;
          if (cyc - last_chg < CD) pre_viol++;
        end else if (sclk && copi != hi_copi) begin
          copi_viol++;
        end
      end else begin
        if (in_frame) begin
          if (exp_q.size() == 0) begin
            check("unexpected_frame", word, 16'hxxxx);
          end else begin
            exp_w = exp_q.pop_front();
            check("frame_word", word, exp_w);
          end
          check("rise_edges", mon_edges, 16);
          check("ncs_low_cycles", cyc - fall_c, 34 * CD);
          check("first_sclk_rise", first_rise - fall_c, CD);
          check("done_at_ncs_rise", done, 1'b1);
          check("idle_lines", {sclk, copi}, 2'b00);
          frames_done++;
          in_frame = 0; have_prev = 1; high_run = 0; wait_ready = 1;
        end
        if (have_prev) high_run++;
        if (wait_ready && req_ready) begin
          check("ready_latency", cyc - frame_acc, 34 * CD + GAP);
          wait_ready = 0;
        end
      end
      prev_sclk = sclk;
      prev_copi = copi;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [6:0] a, input logic [7:0] d,
                      input logic [15:0] frame, input bit keep);
    int n;
    n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_addr = a; req_data = d;
    while (!req_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check("accept_timeout", 1'b0, 1'b1);
      req_valid = 1'b0;
    end else begin
      acc_cyc = cyc + 1;
      exp_q.push_back(frame);
      exp_done++;
      @(negedge clk);
      if (!keep) req_valid = 1'b0;
      req_addr = 7'($urandom);
      req_data = 8'($urandom);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !req_ready) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", (exp_q.size() == 0) && req_ready, 1'b1);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [6:0]  addr;
    logic [7:0]  data;
    logic [15:0] frame;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int n;
    int base;
    logic [6:0] ra;
    logic [7:0] rd;

    vecs[0] = '{7'h00, 8'hA5, 16'h80A5};
    vecs[1] = '{7'h7F, 8'h00, 16'hFF00};
    vecs[2] = '{7'h55, 8'h3C, 16'hD53C};
    vecs[3] = '{7'h2A, 8'hC3, 16'hAAC3};

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_ncs", ncs, 1'b1);
    check("rst_sclk", sclk, 1'b0);
    check("rst_copi", copi, 1'b0);
    check("rst_done", done, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", req_ready, 1'b1);

    // Table-driven single frames
    for (int i = 0; i < 4; i++) begin
      base = frames_done;
      send(vecs[i].addr, vecs[i].data, vecs[i].frame, 1'b0);
      wait_idle();
      check("frame_count", frames_done - base, 1);
    end

    // Back-to-back with req_valid held high
    send(7'h04, 8'h7F, 16'h847F, 1'b1);
    send(7'h02, 8'hFF, 16'h82FF, 1'b0);
    wait_idle();

    // Busy isolation: request pulses while a frame is in flight
    send(7'h11, 8'h22, 16'h9122, 1'b0);
    repeat (10) begin
      @(negedge clk);
      req_valid = 1'b1; req_addr = 7'($urandom); req_data = 8'($urandom);
      @(negedge clk);
      req_valid = 1'b0;
    end
    wait_idle();

    // Mid-frame reset after the 6th rising edge
    send(7'h33, 8'h44, 16'hB344, 1'b0);
    n = 0;
    while (mon_edges < 6 && n < 500) begin
      @(posedge clk);
      n++;
    end
    check("reach_6th_edge", mon_edges >= 6, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_ncs", ncs, 1'b1);
    check("async_rst_sclk", sclk, 1'b0);
    check("async_rst_copi", copi, 1'b0);
    check("async_rst_done", done, 1'b0);
    exp_q.delete();
    exp_done--;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_midreset", req_ready, 1'b1);
    send(7'h01, 8'h3C, 16'h813C, 1'b0);
    wait_idle();

    // Random frames against the frame-format model
    for (int i = 0; i < 6; i++) begin
      ra = 7'($urandom_range(0, 127));
      rd = 8'($urandom_range(0, 255));
      send(ra, rd, {1'b1, ra, rd}, (i < 5) ? 1'($urandom_range(0, 1)) : 1'b0);
    end
    wait_idle();

    repeat (4) @(negedge clk);
    check("leftover_expected", exp_q.size(), 0);
    check("done_pulse_total", done_total, exp_done);
    check("copi_stable_high", copi_viol, 0);
    check("copi_setup_before_rise", pre_viol, 0);
    check("ready_low_in_frame", ready_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=%0d required=done", cyc);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
